// File: rtl/vector_pkg.sv
// Shared definitions for the vector lane packer: lane count, default sample width,
// controller state encoding and a helper that locates a lane inside a packed vector.
package vector_pkg;

  localparam int NUM_LANES     = 4;
  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // Bit offset of the least significant bit of a lane.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vector_lane_packer.sv
// Packs a serial sample stream into 4-lane vectors for vector_max, pulses start,
// then holds the vector until done returns or the wait times out.
module vector_lane_packer
  import vector_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [NUM_LANES*WIDTH-1:0] vec_out,
  output logic                       start_out,
  input  logic                       max_done,
  output logic                       busy,
  output logic [CNT_W-1:0]           vec_count,
  output logic                       timeout_err
);

  localparam int          VW           = NUM_LANES * WIDTH;
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [VW-1:0]    r_vec;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_count;
  logic             r_timeout;

  state_t           w_state_next;
  logic [1:0]       w_idx_next;
  logic [VW-1:0]    w_vec_next;
  logic [7:0]       w_wait_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_timeout_next;
  logic             w_xfer;
  logic             w_close;

  assign in_ready    = (r_state == FILL);
  assign start_out   = (r_state == LAUNCH);
  assign busy        = (r_state == LAUNCH) || (r_state == WAIT);
  assign vec_out     = r_vec;
  assign vec_count   = r_count;
  assign timeout_err = r_timeout;

  assign w_xfer  = in_valid && in_ready;
  assign w_close = in_last || (r_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FILL;
      r_idx      <= 2'd0;
      r_vec      <= '0;
      r_wait_cnt <= 8'd0;
      r_count    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_vec      <= w_vec_next;
      r_wait_cnt <= w_wait_next;
      r_count    <= w_count_next;
      r_timeout  <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_vec_next     = r_vec;
    w_wait_next    = r_wait_cnt;
    w_count_next   = r_count;
    w_timeout_next = r_timeout;

    case (r_state)
      FILL: begin
        if (w_xfer) begin
          // Closing a short group explicitly zeroes every lane above the last one written.
          for (int k = 0; k < NUM_LANES; k++) begin
            if (k == int'(r_idx)) begin
              w_vec_next[lane_lo(k, WIDTH) +: WIDTH] = in_data;
            end else if (w_close && (k > int'(r_idx))) begin
              w_vec_next[lane_lo(k, WIDTH) +: WIDTH] = '0;
            end
          end
          if (w_close) begin
            w_idx_next   = 2'd0;
            w_state_next = LAUNCH;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end
      end

      LAUNCH: begin
        w_wait_next  = 8'd0;
        w_state_next = WAIT;
      end

      WAIT: begin
        if (max_done) begin
          w_count_next = r_count + 1'b1;
          w_vec_next   = '0;
          w_state_next = FILL;
        end else if (r_wait_cnt == TIMEOUT_LAST) begin
          w_timeout_next = 1'b1;
          w_vec_next     = '0;
          w_state_next   = FILL;
        end else begin
          w_wait_next = r_wait_cnt + 8'd1;
        end
      end

      default: begin
        w_vec_next   = '0;
        w_idx_next   = 2'd0;
        w_state_next = FILL;
      end
    endcase
  end

endmodule
